// File: rtl/branch_hazard_controller.sv
// Branch resolution sequencer for the ID stage: stalls on branch-operand hazards,
// then resolves the taken decision, drives PCSrc/IF_Flush and keeps branch statistics.
module branch_hazard_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Branch,
    input  logic             BranchNE,
    input  logic             Equal,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             MEM_MemRead,
    input  logic [REG_W-1:0] MEM_rd,
    output logic             Stall,
    output logic             PCSrc,
    output logic             IF_Flush,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount,
    output logic             IllegalOp,
    output logic [1:0]       DbgState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD2   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_br;
    logic             w_ex_m;
    logic             w_mem_m;
    logic             w_need2;
    logic             w_need1;
    logic             w_stall;
    logic             w_resolve;
    logic             w_taken;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             r_illegal;

    // Register 0 is hardwired, so a zero destination never creates a hazard.
    assign w_br    = Branch | BranchNE;
    assign w_ex_m  = (EX_rd != '0) && ((EX_rd == ID_rs) || (EX_rd == ID_rt));
    assign w_mem_m = (MEM_rd != '0) && ((MEM_rd == ID_rs) || (MEM_rd == ID_rt));
    assign w_need2 = EX_MemRead & w_ex_m;
    assign w_need1 = ~w_need2 & ((EX_RegWrite & w_ex_m) | (MEM_MemRead & w_mem_m));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_resolve = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_br) begin
                    if (w_need2) begin
                        w_stall = 1'b1;
                        w_next  = HOLD2;
                    end else if (w_need1) begin
                        w_stall = 1'b1;
                        w_next  = RESOLVE;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            HOLD2: begin
                w_stall = 1'b1;
                w_next  = RESOLVE;
            end
            RESOLVE: begin
                // A branch flushed away while stalled resolves to nothing.
                w_resolve = w_br;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_taken  = w_resolve & (Branch ? Equal : (BranchNE & ~Equal));
    assign Stall    = Rst & w_stall;
    assign PCSrc    = Rst & w_taken;
    assign IF_Flush = Rst & w_taken;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_resolve && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (w_resolve && Branch && BranchNE) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign BranchCount = r_branch_cnt;
    assign TakenCount  = r_taken_cnt;
    assign IllegalOp   = r_illegal;
    assign DbgState    = r_state;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Bench for branch_hazard_controller: directed scenarios plus randomized traffic
// checked against a countdown-based reference of the stall/resolve rules.
module tb_branch_hazard_controller;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Branch, BranchNE, Equal;
    logic [4:0]  ID_rs, ID_rt, EX_rd, MEM_rd;
    logic        EX_RegWrite, EX_MemRead, MEM_MemRead;
    logic        Stall, PCSrc, IF_Flush, IllegalOp;
    logic [15:0] BranchCount, TakenCount;
    logic [1:0]  DbgState;
    logic        s2_stall, s2_pcsrc, s2_flush, s2_illegal;
    logic [1:0]  s2_bc, s2_tc, s2_dbg;

    int n_vec = 0;
    int n_err = 0;

    branch_hazard_controller #(.REG_W(5), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Branch(Branch), .BranchNE(BranchNE), .Equal(Equal),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .MEM_MemRead(MEM_MemRead), .MEM_rd(MEM_rd),
        .Stall(Stall), .PCSrc(PCSrc), .IF_Flush(IF_Flush),
        .BranchCount(BranchCount), .TakenCount(TakenCount),
        .IllegalOp(IllegalOp), .DbgState(DbgState)
    );

    branch_hazard_controller #(.REG_W(5), .CNT_W(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Branch(Branch), .BranchNE(BranchNE), .Equal(Equal),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .MEM_MemRead(MEM_MemRead), .MEM_rd(MEM_rd),
        .Stall(s2_stall), .PCSrc(s2_pcsrc), .IF_Flush(s2_flush),
        .BranchCount(s2_bc), .TakenCount(s2_tc),
        .IllegalOp(s2_illegal), .DbgState(s2_dbg)
    );

    // Clock and reset
    always #5 Clk = ~Clk;

    // Driver tasks: inputs change 1ns after the rising edge, checks happen 2ns after it
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        Branch = 0; BranchNE = 0; Equal = 0;
        ID_rs = 0; ID_rt = 0; EX_RegWrite = 0; EX_MemRead = 0; EX_rd = 0;
        MEM_MemRead = 0; MEM_rd = 0;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        set_idle();
        step();
        step();
        Rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({Stall, PCSrc, IF_Flush, IllegalOp} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000", {Stall, PCSrc, IF_Flush, IllegalOp});
        end
        n_vec++;
        if ({BranchCount, TakenCount} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", BranchCount, TakenCount);
        end
    endtask

    task automatic test_taken_no_hazard();
        do_reset();
        step();
        Branch = 1; Equal = 1; ID_rs = 3; ID_rt = 4;
        #1;
        n_vec++;
        if ({Stall, PCSrc, IF_Flush} !== 3'b011) begin
            n_err++;
            $display("FAIL beq_taken_now: got %b want 011", {Stall, PCSrc, IF_Flush});
        end
        step();
        set_idle();
        #1;
        n_vec++;
        if (BranchCount !== 16'd1 || TakenCount !== 16'd1) begin
            n_err++;
            $display("FAIL beq_counts: got %0d/%0d want 1/1", BranchCount, TakenCount);
        end
    endtask

    task automatic test_bne_alu_hazard();
        do_reset();
        step();
        BranchNE = 1; Equal = 1; EX_RegWrite = 1; EX_rd = 8; ID_rs = 8; ID_rt = 2;
        #1;
        n_vec++;
        if ({Stall, PCSrc, IF_Flush} !== 3'b100) begin
            n_err++;
            $display("FAIL bne_stall1: got %b want 100", {Stall, PCSrc, IF_Flush});
        end
        step();
        #1;
        n_vec++;
        if ({Stall, PCSrc, IF_Flush} !== 3'b000) begin
            n_err++;
            $display("FAIL bne_resolve: got %b want 000", {Stall, PCSrc, IF_Flush});
        end
        step();
        set_idle();
        #1;
        n_vec++;
        if (BranchCount !== 16'd1 || TakenCount !== 16'd0) begin
            n_err++;
            $display("FAIL bne_counts: got %0d/%0d want 1/0", BranchCount, TakenCount);
        end
    endtask

    task automatic test_load_ex();
        do_reset();
        step();
        Branch = 1; Equal = 1; EX_MemRead = 1; EX_rd = 9; ID_rs = 1; ID_rt = 9;
        #1;
        n_vec++;
        if ({Stall, PCSrc} !== 2'b10) begin
            n_err++;
            $display("FAIL load_stall1: got %b want 10", {Stall, PCSrc});
        end
        step();
        #1;
        n_vec++;
        if ({Stall, PCSrc} !== 2'b10) begin
            n_err++;
            $display("FAIL load_stall2: got %b want 10", {Stall, PCSrc});
        end
        step();
        #1;
        n_vec++;
        if ({Stall, PCSrc, IF_Flush} !== 3'b011) begin
            n_err++;
            $display("FAIL load_resolve: got %b want 011", {Stall, PCSrc, IF_Flush});
        end
        step();
        set_idle();
        #1;
        n_vec++;
        if (BranchCount !== 16'd1 || TakenCount !== 16'd1) begin
            n_err++;
            $display("FAIL load_counts: got %0d/%0d want 1/1", BranchCount, TakenCount);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        step();
        Branch = 1; Equal = 0; EX_MemRead = 1; EX_rd = 0; ID_rs = 0; ID_rt = 5;
        MEM_MemRead = 1; MEM_rd = 0;
        #1;
        n_vec++;
        if ({Stall, PCSrc, IF_Flush} !== 3'b000) begin
            n_err++;
            $display("FAIL zero_reg_nostall: got %b want 000", {Stall, PCSrc, IF_Flush});
        end
        step();
        set_idle();
        #1;
        n_vec++;
        if (BranchCount !== 16'd1 || TakenCount !== 16'd0) begin
            n_err++;
            $display("FAIL zero_reg_counts: got %0d/%0d want 1/0", BranchCount, TakenCount);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        step();
        Branch = 1; Equal = 1; EX_MemRead = 1; EX_rd = 7; ID_rs = 7;
        step();
        #1;
        n_vec++;
        if (Stall !== 1'b1) begin
            n_err++;
            $display("FAIL hold2_stall: got %b want 1", Stall);
        end
        Rst = 1'b0;
        #1;
        n_vec++;
        if ({Stall, PCSrc, IF_Flush} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_in_hold2: got %b want 000", {Stall, PCSrc, IF_Flush});
        end
        step();
        Rst = 1'b1;
        // Still presenting a hazard-free branch: from IDLE it must resolve at once.
        EX_MemRead = 0; EX_rd = 0;
        #1;
        n_vec++;
        if ({Stall, PCSrc, BranchCount} !== {2'b01, 16'd0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got stall=%b pcsrc=%b bc=%0d want 0/1/0",
                     Stall, PCSrc, BranchCount);
        end
        step();
        set_idle();
    endtask

    task automatic test_saturation_illegal();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            Branch = 1; Equal = 1;
            step();
        end
        set_idle();
        #1;
        n_vec++;
        if (s2_bc !== 2'd3 || s2_tc !== 2'd3) begin
            n_err++;
            $display("FAIL sat_counts: got %0d/%0d want 3/3", s2_bc, s2_tc);
        end
        n_vec++;
        if (BranchCount !== 16'd5 || TakenCount !== 16'd5) begin
            n_err++;
            $display("FAIL wide_counts: got %0d/%0d want 5/5", BranchCount, TakenCount);
        end
        Branch = 1; BranchNE = 1;
        step();
        set_idle();
        step();
        step();
        #1;
        n_vec++;
        if (IllegalOp !== 1'b1 || s2_illegal !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_sticky: got %b/%b want 1/1", IllegalOp, s2_illegal);
        end
    endtask

    // Reference: a countdown of cycles until the resolve cycle
    task automatic test_random_back_to_back();
        int        wait_cnt;
        int        bc, tc;
        bit        ill, br, exm, memm, need2, need1, res, taken, e_stall;
        do_reset();
        wait_cnt = 0; bc = 0; tc = 0; ill = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            br          = ($urandom_range(0, 3) != 0);
            Branch      = br && ($urandom_range(0, 1) == 1);
            BranchNE    = br && (!Branch || ($urandom_range(0, 31) == 0));
            Equal       = $urandom_range(0, 1);
            ID_rs       = $urandom_range(0, 3);
            ID_rt       = $urandom_range(0, 3);
            EX_rd       = $urandom_range(0, 3);
            MEM_rd      = $urandom_range(0, 3);
            EX_RegWrite = $urandom_range(0, 1);
            EX_MemRead  = ($urandom_range(0, 3) == 0);
            MEM_MemRead = ($urandom_range(0, 2) == 0);
            #1;
            exm   = (EX_rd != 0) && (EX_rd == ID_rs || EX_rd == ID_rt);
            memm  = (MEM_rd != 0) && (MEM_rd == ID_rs || MEM_rd == ID_rt);
            need2 = EX_MemRead && exm;
            need1 = !need2 && ((EX_RegWrite && exm) || (MEM_MemRead && memm));
            res = 0; e_stall = 0;
            if (wait_cnt >= 2) begin
                e_stall = 1; wait_cnt = wait_cnt - 1;
            end else if (wait_cnt == 1) begin
                res = br; wait_cnt = 0;
            end else if (br && need2) begin
                e_stall = 1; wait_cnt = 2;
            end else if (br && need1) begin
                e_stall = 1; wait_cnt = 1;
            end else begin
                res = br;
            end
            taken = res && (Branch ? Equal : (BranchNE && !Equal));
            n_vec++;
            if ({Stall, PCSrc, IF_Flush} !== {e_stall, taken, taken}) begin
                n_err++;
                $display("FAIL rand_outputs cyc %0d: got %b want %b", cyc,
                         {Stall, PCSrc, IF_Flush}, {e_stall, taken, taken});
            end
            n_vec++;
            if (BranchCount !== bc[15:0] || TakenCount !== tc[15:0] || IllegalOp !== ill) begin
                n_err++;
                $display("FAIL rand_state cyc %0d: got %0d/%0d/%b want %0d/%0d/%b", cyc,
                         BranchCount, TakenCount, IllegalOp, bc, tc, ill);
            end
            if (res && bc < 65535) bc++;
            if (taken && tc < 65535) tc++;
            if (res && Branch && BranchNE) ill = 1;
            step();
        end
        set_idle();
    endtask

    initial begin
        Rst = 1'b0;
        set_idle();
        test_reset();
        test_taken_no_hazard();
        test_bne_alu_hazard();
        test_load_ex();
        test_zero_reg();
        test_reset_mid_stall();
        test_saturation_illegal();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
